// File: rtl/eth_pcs_pkg.sv
// Shared types and helpers for the 64b/66b PCS block-lock engine.
// Holds the lane state encoding and the sync-header classification.
package eth_pcs_pkg;

    typedef enum logic [1:0] {
        LANE_HUNT      = 2'd0,
        LANE_SLIP_WAIT = 2'd1,
        LANE_LOCKED    = 2'd2
    } lane_state_t;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    function automatic logic hdr_good(input logic [1:0] hdr);
        logic good;
        case (hdr)
            SYNC_DATA, SYNC_CTRL: good = 1'b1;
            default:              good = 1'b0;
        endcase
        return good;
    endfunction

endpackage

// File: rtl/eth_lane_block_lock.sv
// Single-lane 64b/66b block-lock FSM: hunts for lock with bit slips,
// monitors lock quality per window and keeps a saturating bad-header count.
module eth_lane_block_lock
    import eth_pcs_pkg::*;
#(
    parameter int LOCK_CNT  = 64,
    parameter int WINDOW    = 64,
    parameter int BAD_LIMIT = 16,
    parameter int SLIP_WAIT = 32,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lane_en,
    input  logic                 hdr_valid,
    input  logic [1:0]           hdr,
    input  logic                 clr_stats,
    output logic                 slip,
    output logic                 block_lock,
    output logic [ERR_CNT_W-1:0] bad_hdr_cnt
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
    localparam int WIN_W  = $clog2(WINDOW + 1);
    localparam int BAD_W  = $clog2(BAD_LIMIT + 1);

    // Compare against "one before the threshold" so counters never hold the threshold itself.
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(BAD_LIMIT - 1);

    lane_state_t          state_r, state_s;
    logic [GOOD_W-1:0]    good_cnt_r, good_cnt_s;
    logic [WAIT_W-1:0]    wait_cnt_r, wait_cnt_s;
    logic [WIN_W-1:0]     win_cnt_r, win_cnt_s;
    logic [BAD_W-1:0]     bad_cnt_r, bad_cnt_s;
    logic                 slip_r, slip_s;
    logic                 lock_r, lock_s;
    logic [ERR_CNT_W-1:0] err_cnt_r, err_cnt_s;
    logic                 hdr_ok_s;
    logic                 bad_seen_s;

    assign hdr_ok_s   = hdr_good(hdr);
    assign bad_seen_s = lane_en & hdr_valid & ~hdr_ok_s;

    // Lane FSM next-state and counter update
    always_comb begin
        state_s    = state_r;
        good_cnt_s = good_cnt_r;
        wait_cnt_s = wait_cnt_r;
        win_cnt_s  = win_cnt_r;
        bad_cnt_s  = bad_cnt_r;
        lock_s     = lock_r;
        slip_s     = 1'b0;
        if (!lane_en) begin
            state_s    = LANE_HUNT;
            good_cnt_s = GOOD_W'(0);
            wait_cnt_s = WAIT_W'(0);
            win_cnt_s  = WIN_W'(0);
            bad_cnt_s  = BAD_W'(0);
            lock_s     = 1'b0;
        end else if (hdr_valid) begin
            case (state_r)
                LANE_HUNT: begin
                    lock_s = 1'b0;
                    if (!hdr_ok_s) begin
                        slip_s     = 1'b1;
                        good_cnt_s = GOOD_W'(0);
                        wait_cnt_s = WAIT_W'(0);
                        state_s    = LANE_SLIP_WAIT;
                    end else if (good_cnt_r == GOOD_LAST) begin
                        good_cnt_s = GOOD_W'(0);
                        win_cnt_s  = WIN_W'(0);
                        bad_cnt_s  = BAD_W'(0);
                        lock_s     = 1'b1;
                        state_s    = LANE_LOCKED;
                    end else begin
                        good_cnt_s = good_cnt_r + GOOD_W'(1);
                    end
                end
                LANE_SLIP_WAIT: begin
                    lock_s = 1'b0;
                    if (wait_cnt_r == WAIT_LAST) begin
                        wait_cnt_s = WAIT_W'(0);
                        good_cnt_s = GOOD_W'(0);
                        state_s    = LANE_HUNT;
                    end else begin
                        wait_cnt_s = wait_cnt_r + WAIT_W'(1);
                    end
                end
                LANE_LOCKED: begin
                    // Lock loss takes priority over a window rollover on the same header.
                    if (!hdr_ok_s && (bad_cnt_r == BAD_LAST)) begin
                        slip_s     = 1'b1;
                        lock_s     = 1'b0;
                        win_cnt_s  = WIN_W'(0);
                        bad_cnt_s  = BAD_W'(0);
                        wait_cnt_s = WAIT_W'(0);
                        state_s    = LANE_SLIP_WAIT;
                    end else if (win_cnt_r == WIN_LAST) begin
                        win_cnt_s = WIN_W'(0);
                        bad_cnt_s = BAD_W'(0);
                    end else begin
                        win_cnt_s = win_cnt_r + WIN_W'(1);
                        bad_cnt_s = hdr_ok_s ? bad_cnt_r : (bad_cnt_r + BAD_W'(1));
                    end
                end
                default: begin
                    state_s    = LANE_HUNT;
                    good_cnt_s = GOOD_W'(0);
                    wait_cnt_s = WAIT_W'(0);
                    win_cnt_s  = WIN_W'(0);
                    bad_cnt_s  = BAD_W'(0);
                    lock_s     = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Saturating bad-header statistic; a clear coinciding with a bad header leaves it at one
    always_comb begin
        err_cnt_s = err_cnt_r;
        if (clr_stats) begin
            err_cnt_s = bad_seen_s ? ERR_CNT_W'(1) : ERR_CNT_W'(0);
        end else if (bad_seen_s && !(&err_cnt_r)) begin
            err_cnt_s = err_cnt_r + ERR_CNT_W'(1);
        end else begin
            err_cnt_s = err_cnt_r;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= LANE_HUNT;
            good_cnt_r <= GOOD_W'(0);
            wait_cnt_r <= WAIT_W'(0);
            win_cnt_r  <= WIN_W'(0);
            bad_cnt_r  <= BAD_W'(0);
            slip_r     <= 1'b0;
            lock_r     <= 1'b0;
            err_cnt_r  <= ERR_CNT_W'(0);
        end else begin
            state_r    <= state_s;
            good_cnt_r <= good_cnt_s;
            wait_cnt_r <= wait_cnt_s;
            win_cnt_r  <= win_cnt_s;
            bad_cnt_r  <= bad_cnt_s;
            slip_r     <= slip_s;
            lock_r     <= lock_s;
            err_cnt_r  <= err_cnt_s;
        end
    end

    assign slip        = slip_r;
    assign block_lock  = lock_r;
    assign bad_hdr_cnt = err_cnt_r;

endmodule

// File: rtl/eth_pcs_block_lock.sv
// Multi-lane 64b/66b block-lock engine: one independent lock FSM per lane
// plus a registered aggregate lock indication.
module eth_pcs_block_lock
    import eth_pcs_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int LOCK_CNT  = 64,
    parameter int WINDOW    = 64,
    parameter int BAD_LIMIT = 16,
    parameter int SLIP_WAIT = 32,
    parameter int ERR_CNT_W = 16
) (
    input  logic                           core_clk,
    input  logic                           core_resetn,
    input  logic [NUM_LANES-1:0]           lane_en,
    input  logic [NUM_LANES-1:0]           rx_hdr_valid,
    input  logic [2*NUM_LANES-1:0]         rx_hdr,
    input  logic                           clr_stats,
    output logic [NUM_LANES-1:0]           rx_slip,
    output logic [NUM_LANES-1:0]           block_lock,
    output logic                           all_locked,
    output logic [NUM_LANES*ERR_CNT_W-1:0] bad_hdr_cnt
);

    logic all_locked_r;
    logic all_locked_s;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        eth_lane_block_lock #(
            .LOCK_CNT  (LOCK_CNT),
            .WINDOW    (WINDOW),
            .BAD_LIMIT (BAD_LIMIT),
            .SLIP_WAIT (SLIP_WAIT),
            .ERR_CNT_W (ERR_CNT_W)
        ) u_lane (
            .clk         (core_clk),
            .rst_n       (core_resetn),
            .lane_en     (lane_en[i]),
            .hdr_valid   (rx_hdr_valid[i]),
            .hdr         (rx_hdr[2*i +: 2]),
            .clr_stats   (clr_stats),
            .slip        (rx_slip[i]),
            .block_lock  (block_lock[i]),
            .bad_hdr_cnt (bad_hdr_cnt[i*ERR_CNT_W +: ERR_CNT_W])
        );
    end

    // Disabled lanes do not block aggregate lock, but at least one lane must be enabled
    always_comb begin
        all_locked_s = (|lane_en) & (&(block_lock | ~lane_en));
    end

    // Aggregate lock register, one cycle behind the per-lane lock flags
    always_ff @(posedge core_clk or negedge core_resetn) begin
        if (!core_resetn) begin
            all_locked_r <= 1'b0;
        end else begin
            all_locked_r <= all_locked_s;
        end
    end

    assign all_locked = all_locked_r;

endmodule

// File: tb/tb_eth_pcs_block_lock.sv
// Self-checking bench for eth_pcs_block_lock: directed scenarios plus random
// traffic, compared every cycle against a behavioural per-lane lock model.
module tb_eth_pcs_block_lock;

    localparam int NL        = 4;
    localparam int LOCK_CNT  = 64;
    localparam int WINDOW    = 64;
    localparam int BAD_LIMIT = 16;
    localparam int SLIP_WAIT = 32;
    localparam int ERR_W     = 4;
    localparam int HW        = 2 * NL;
    localparam int CW        = NL * ERR_W;
    localparam int ERR_MAX   = (1 << ERR_W) - 1;

    logic          core_clk = 1'b0;
    logic          core_resetn;
    logic [NL-1:0] lane_en;
    logic [NL-1:0] rx_hdr_valid;
    logic [HW-1:0] rx_hdr;
    logic          clr_stats;
    logic [NL-1:0] rx_slip;
    logic [NL-1:0] block_lock;
    logic          all_locked;
    logic [CW-1:0] bad_hdr_cnt;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: lock flag, hunt progress, headers still to ignore, window tallies
    bit            m_locked [NL];
    int            m_good   [NL];
    int            m_ignore [NL];
    int            m_win    [NL];
    int            m_wbad   [NL];
    int            m_err    [NL];
    bit            m_slip   [NL];
    bit            m_all;
    logic [NL-1:0] prev_slip;

    always #5 core_clk = ~core_clk;

    eth_pcs_block_lock #(
        .NUM_LANES (NL),
        .LOCK_CNT  (LOCK_CNT),
        .WINDOW    (WINDOW),
        .BAD_LIMIT (BAD_LIMIT),
        .SLIP_WAIT (SLIP_WAIT),
        .ERR_CNT_W (ERR_W)
    ) dut (
        .core_clk     (core_clk),
        .core_resetn  (core_resetn),
        .lane_en      (lane_en),
        .rx_hdr_valid (rx_hdr_valid),
        .rx_hdr       (rx_hdr),
        .clr_stats    (clr_stats),
        .rx_slip      (rx_slip),
        .block_lock   (block_lock),
        .all_locked   (all_locked),
        .bad_hdr_cnt  (bad_hdr_cnt)
    );

    function automatic bit is_good(input logic [1:0] h);
        return (h == 2'b01) || (h == 2'b10);
    endfunction

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_hdr();
        return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_locked[i] = 1'b0;
            m_good[i]   = 0;
            m_ignore[i] = 0;
            m_win[i]    = 0;
            m_wbad[i]   = 0;
            m_err[i]    = 0;
            m_slip[i]   = 1'b0;
        end
        m_all     = 1'b0;
        prev_slip = '0;
    endtask

    task automatic model_step();
        bit all_n;
        all_n = (lane_en != '0);
        for (int i = 0; i < NL; i++) begin
            if (lane_en[i] && !m_locked[i]) all_n = 1'b0;
        end
        m_all = all_n;
        for (int i = 0; i < NL; i++) begin
            logic [1:0] h;
            bit         g;
            bit         bad_seen;
            h         = rx_hdr[2*i +: 2];
            g         = is_good(h);
            m_slip[i] = 1'b0;
            bad_seen  = lane_en[i] && rx_hdr_valid[i] && !g;
            if (!lane_en[i]) begin
                m_locked[i] = 1'b0;
                m_good[i]   = 0;
                m_ignore[i] = 0;
                m_win[i]    = 0;
                m_wbad[i]   = 0;
            end else if (rx_hdr_valid[i]) begin
                if (m_ignore[i] > 0) begin
                    m_ignore[i]--;
                end else if (m_locked[i]) begin
                    m_win[i]++;
                    if (!g) m_wbad[i]++;
                    if (m_wbad[i] == BAD_LIMIT) begin
                        m_locked[i] = 1'b0;
                        m_slip[i]   = 1'b1;
                        m_ignore[i] = SLIP_WAIT;
                        m_win[i]    = 0;
                        m_wbad[i]   = 0;
                    end else if (m_win[i] == WINDOW) begin
                        m_win[i]  = 0;
                        m_wbad[i] = 0;
                    end
                end else if (g) begin
                    m_good[i]++;
                    if (m_good[i] == LOCK_CNT) begin
                        m_locked[i] = 1'b1;
                        m_good[i]   = 0;
                        m_win[i]    = 0;
                        m_wbad[i]   = 0;
                    end
                end else begin
                    m_slip[i]   = 1'b1;
                    m_good[i]   = 0;
                    m_ignore[i] = SLIP_WAIT;
                end
            end
            if (clr_stats) m_err[i] = bad_seen ? 1 : 0;
            else if (bad_seen && m_err[i] < ERR_MAX) m_err[i]++;
        end
    endtask

    task automatic check_out(input string tag);
        logic [NL-1:0] e_lock;
        logic [NL-1:0] e_slip;
        logic [CW-1:0] e_cnt;
        for (int i = 0; i < NL; i++) begin
            e_lock[i]               = m_locked[i];
            e_slip[i]               = m_slip[i];
            e_cnt[i*ERR_W +: ERR_W] = ERR_W'(m_err[i]);
        end
        checks++;
        assert (block_lock === e_lock) else begin
            failures++;
            $error("FAIL %s block_lock: got %b expected %b", tag, block_lock, e_lock);
        end
        checks++;
        assert (rx_slip === e_slip) else begin
            failures++;
            $error("FAIL %s rx_slip: got %b expected %b", tag, rx_slip, e_slip);
        end
        checks++;
        assert (all_locked === m_all) else begin
            failures++;
            $error("FAIL %s all_locked: got %b expected %b", tag, all_locked, m_all);
        end
        checks++;
        assert (bad_hdr_cnt === e_cnt) else begin
            failures++;
            $error("FAIL %s bad_hdr_cnt: got %h expected %h", tag, bad_hdr_cnt, e_cnt);
        end
        checks++;
        assert ((rx_slip & prev_slip) === '0) else begin
            failures++;
            $error("FAIL %s slip_width: got %b after %b expected no overlap", tag, rx_slip, prev_slip);
        end
        prev_slip = rx_slip;
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge core_clk);
        #1;
        check_out(tag);
    endtask

    // One header on every lane, bad where masked, sometimes preceded by an idle cycle
    task automatic hdr_cycle(input string tag, input logic [NL-1:0] bad_mask);
        clr_stats = 1'b0;
        if ($urandom_range(0, 7) == 0) begin
            rx_hdr_valid = '0;
            rx_hdr       = HW'($urandom);
            cycle({tag, "_idle"});
        end
        rx_hdr_valid = '1;
        for (int i = 0; i < NL; i++) rx_hdr[2*i +: 2] = bad_mask[i] ? bad_hdr() : good_hdr();
        cycle(tag);
    endtask

    task automatic expect_bits(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        core_resetn  = 1'b0;
        lane_en      = '0;
        rx_hdr_valid = '0;
        rx_hdr       = '0;
        clr_stats    = 1'b0;
        model_reset();
        #12;
        check_out("reset");
        @(posedge core_clk);
        #1;
        core_resetn = 1'b1;
        lane_en     = '1;

        // Initial hunt; lane 2 sees a bad header after ten good ones
        for (int n = 0; n < 64; n++) begin
            hdr_cycle("hunt", (n == 10) ? 4'b0100 : 4'b0000);
            if (n == 10) expect_bits("slip_lane2", 32'(rx_slip), 32'h4);
        end
        expect_bits("lock_first", 32'(block_lock), 32'hB);
        for (int n = 64; n < 107; n++) hdr_cycle("hunt2", 4'b0000);
        expect_bits("lock_lane2", 32'(block_lock), 32'hF);
        expect_bits("all_locked_lag", 32'(all_locked), 32'h0);
        expect_bits("err_lane2", 32'(bad_hdr_cnt[2*ERR_W +: ERR_W]), 32'h1);
        rx_hdr_valid = '0;
        cycle("all_rise");
        expect_bits("all_locked_rise", 32'(all_locked), 32'h1);

        // Align lane 0 to a window boundary, then probe the bad-header limit
        for (int k = 0; k < WINDOW && m_win[0] != 0; k++) hdr_cycle("align", 4'b0000);
        for (int p = 0; p < WINDOW; p++) hdr_cycle("win1", (p < 15) ? 4'b0001 : 4'b0000);
        expect_bits("win1_hold", 32'(block_lock), 32'hF);
        for (int p = 0; p < WINDOW; p++) begin
            hdr_cycle("win2", ((p < 60 && p % 4 == 1) || p == 63) ? 4'b0001 : 4'b0000);
            if (p == 62) expect_bits("win2_hold", 32'(block_lock), 32'hF);
        end
        expect_bits("win2_drop_lock", 32'(block_lock), 32'hE);
        expect_bits("win2_drop_slip", 32'(rx_slip), 32'h1);
        rx_hdr_valid = '0;
        cycle("win2_after");
        expect_bits("all_locked_drop", 32'(all_locked), 32'h0);

        // Relock, then partial and zero lane enables
        for (int n = 0; n < 100; n++) hdr_cycle("relock", 4'b0000);
        expect_bits("relock_all", 32'(block_lock), 32'hF);
        lane_en      = 4'b0111;
        rx_hdr_valid = 4'b0111;
        for (int i = 0; i < NL; i++) rx_hdr[2*i +: 2] = good_hdr();
        cycle("en0111_a");
        cycle("en0111_b");
        expect_bits("en0111_lock", 32'(block_lock), 32'h7);
        expect_bits("en0111_all", 32'(all_locked), 32'h1);
        lane_en = '0;
        cycle("en0_a");
        expect_bits("en0_all", 32'(all_locked), 32'h0);
        expect_bits("en0_lock", 32'(block_lock), 32'h0);

        // Statistics: clear, saturate, clear with coincident bad header
        lane_en      = '1;
        rx_hdr_valid = '0;
        clr_stats    = 1'b1;
        cycle("clr");
        expect_bits("clr_zero", 32'(bad_hdr_cnt), 32'h0);
        for (int n = 0; n < 20; n++) hdr_cycle("sat", 4'b0010);
        expect_bits("sat_lane1", 32'(bad_hdr_cnt[ERR_W +: ERR_W]), 32'hF);
        rx_hdr_valid = '1;
        for (int i = 0; i < NL; i++) rx_hdr[2*i +: 2] = (i == 1) ? 2'b11 : good_hdr();
        clr_stats = 1'b1;
        cycle("clr_bad");
        expect_bits("clr_bad_cnt", 32'(bad_hdr_cnt), 32'h0010);
        clr_stats = 1'b0;

        // Random traffic at several bad-header rates
        for (int seg = 0; seg < 4; seg++) begin
            int rate;
            rate = (seg == 0) ? 0 : (seg == 1) ? 200 : (seg == 2) ? 40 : 6;
            for (int n = 0; n < 500; n++) begin
                lane_en   = ($urandom_range(0, 31) == 0) ? NL'($urandom) : '1;
                clr_stats = ($urandom_range(0, 63) == 0);
                for (int i = 0; i < NL; i++) begin
                    rx_hdr_valid[i]  = ($urandom_range(0, 3) != 0);
                    rx_hdr[2*i +: 2] = (rate != 0 && $urandom_range(1, rate) == 1) ? bad_hdr() : good_hdr();
                end
                cycle("rand");
            end
        end

        // Asynchronous reset while locked, then reacquire
        lane_en = '1;
        for (int n = 0; n < 200; n++) hdr_cycle("pre_reset", 4'b0000);
        expect_bits("pre_reset_lock", 32'(block_lock), 32'hF);
        #3;
        core_resetn = 1'b0;
        #1;
        expect_bits("arst_lock", 32'(block_lock), 32'h0);
        expect_bits("arst_slip", 32'(rx_slip), 32'h0);
        expect_bits("arst_all", 32'(all_locked), 32'h0);
        expect_bits("arst_cnt", 32'(bad_hdr_cnt), 32'h0);
        model_reset();
        @(posedge core_clk);
        #1;
        core_resetn = 1'b1;
        for (int n = 0; n < LOCK_CNT; n++) hdr_cycle("post_reset", 4'b0000);
        expect_bits("post_reset_lock", 32'(block_lock), 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
